// File: rtl/l_instr_seq.sv
// l_instr_seq: sequencer for the 4-bit logic unit (l_instr).
//
// Takes one operation request at a time and drives the unit's sel/op1/op2
// inputs. It holds them for EXEC_CYCLES cycles, then captures the 8-bit
// result and flags opcodes above 8 as errors. When LCD_EN is set, it sends
// the result to the LCD character writer as two uppercase hex digits and
// then SEP_CHAR.
//
// Handshake semantics (both interfaces): a transfer happens on a rising
// clk edge where valid && ready are both high. A producer holds its payload
// stable while valid is high and ready is low. ready never depends on valid.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req_valid  request present
//   req_ready  request accepted this cycle (IDLE and not in reset)
//   req_sel    opcode (0 AND .. 8 SLL, >8 illegal)
//   req_op1    operand 1
//   req_op2    operand 2
//   lu_sel     logic unit sel, held from accept until the next accept
//   lu_op1     logic unit op1
//   lu_op2     logic unit op2
//   lu_res     logic unit result
//   res_valid  one-cycle result strobe
//   res_data   captured result, held until the next capture
//   res_err    illegal opcode flag, held with res_data
//   lcd_valid  character available
//   lcd_ready  LCD writer accepts the character
//   lcd_char   ASCII character
//   busy       high whenever the sequencer is not IDLE
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 REPORT, 3 EMIT)
module l_instr_seq #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          LCD_EN      = 1'b1,
    parameter logic [7:0]  SEP_CHAR    = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_sel,
    input  logic [3:0] req_op1,
    input  logic [3:0] req_op2,
    output logic [3:0] lu_sel,
    output logic [3:0] lu_op1,
    output logic [3:0] lu_op2,
    input  logic [7:0] lu_res,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       lcd_valid,
    input  logic       lcd_ready,
    output logic [7:0] lcd_char,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_REPORT = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    // The counter is loaded with EXEC_CYCLES-1 so that the capture happens
    // in the last of the EXEC_CYCLES hold cycles.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state_q;
    logic [3:0] lu_sel_q;
    logic [3:0] lu_op1_q;
    logic [3:0] lu_op2_q;
    logic [3:0] cnt_q;
    logic [1:0] idx_q;
    logic [7:0] res_data_q;
    logic       res_err_q;
    logic       res_valid_q;
    logic       lcd_valid_q;
    logic [7:0] lcd_char_q;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Character selected by the emission index. An error result prints "ER".
    function automatic logic [7:0] char_at(input logic [1:0] idx,
                                           input logic [7:0] data,
                                           input logic       err);
        case (idx)
            2'd0:    return err ? 8'h45 : hex_char(data[7:4]);
            2'd1:    return err ? 8'h52 : hex_char(data[3:0]);
            default: return SEP_CHAR;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lu_sel_q    <= 4'h0;
            lu_op1_q    <= 4'h0;
            lu_op2_q    <= 4'h0;
            cnt_q       <= 4'h0;
            idx_q       <= 2'd0;
            res_data_q  <= 8'h00;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            lcd_valid_q <= 1'b0;
            lcd_char_q  <= 8'h00;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // req_ready is high in every IDLE cycle outside reset.
                    if (req_valid) begin
                        lu_sel_q <= req_sel;
                        lu_op1_q <= req_op1;
                        lu_op2_q <= req_op2;
                        cnt_q    <= CNT_INIT;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q != 4'h0) begin
                        cnt_q <= cnt_q - 4'h1;
                    end else begin
                        res_data_q  <= (lu_sel_q > 4'd8) ? 8'h00 : lu_res;
                        res_err_q   <= (lu_sel_q > 4'd8);
                        res_valid_q <= 1'b1;
                        state_q     <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (LCD_EN) begin
                        idx_q       <= 2'd0;
                        lcd_valid_q <= 1'b1;
                        lcd_char_q  <= char_at(2'd0, res_data_q, res_err_q);
                        state_q     <= S_EMIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    // lcd_valid is always high here, so lcd_ready alone
                    // completes the handshake. Outside EMIT it is ignored.
                    if (lcd_ready) begin
                        if (idx_q == 2'd2) begin
                            lcd_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            lcd_char_q <= char_at(idx_q + 2'd1, res_data_q, res_err_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;
    assign lu_sel    = lu_sel_q;
    assign lu_op1    = lu_op1_q;
    assign lu_op2    = lu_op2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign lcd_valid = lcd_valid_q;
    assign lcd_char  = lcd_char_q;

endmodule

// File: tb/tb_l_instr_seq.sv
// Testbench for l_instr_seq.
// The bench uses three instances:
//   dut_a: EXEC_CYCLES=1, LCD_EN=1
//   dut_b: EXEC_CYCLES=4, LCD_EN=0
//   dut_c: EXEC_CYCLES=1, LCD_EN=0
// A behavioural logic-unit model drives each lu_res.
// Inputs are driven, and outputs sampled, on the falling edge.
module tb_l_instr_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_sel = 4'h0;
  logic [3:0] req_op1 = 4'h0;
  logic [3:0] req_op2 = 4'h0;
  logic lcd_ready = 1'b0;

  logic req_valid_a = 1'b0, req_valid_b = 1'b0, req_valid_c = 1'b0;
  logic req_ready_a, req_ready_b, req_ready_c;
  logic [3:0] lu_sel_a, lu_op1_a, lu_op2_a;
  logic [3:0] lu_sel_b, lu_op1_b, lu_op2_b;
  logic [3:0] lu_sel_c, lu_op1_c, lu_op2_c;
  logic [7:0] lu_res_a, lu_res_b, lu_res_c;
  logic res_valid_a, res_valid_b, res_valid_c;
  logic [7:0] res_data_a, res_data_b, res_data_c;
  logic res_err_a, res_err_b, res_err_c;
  logic lcd_valid_a, lcd_valid_b, lcd_valid_c;
  logic [7:0] lcd_char_a, lcd_char_b, lcd_char_c;
  logic busy_a, busy_b, busy_c;
  logic [1:0] dbg_state_a, dbg_state_b, dbg_state_c;

  logic       ovr_en_b = 1'b0;
  logic [7:0] ovr_val_b = 8'h00;

  int n_tests = 0;
  int n_fail = 0;
  int c_pulses = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- logic unit model ----------------
  function automatic logic [7:0] lu_model(input logic [3:0] s, input logic [3:0] a,
                                          input logic [3:0] b);
    case (s)
      4'd0: return {4'h0, a & b};
      4'd1: return {4'h0, a | b};
      4'd2: return {4'h0, a ^ b};
      4'd3: return {4'h0, ~a};
      4'd4: return {4'h0, ~(a & b)};
      4'd5: return {4'h0, ~(a | b)};
      4'd6: return {4'h0, ~(a ^ b)};
      4'd7: return {4'h0, a} >> b;
      4'd8: return {4'h0, a} << b;
      default: return 8'hFF;
    endcase
  endfunction

  assign lu_res_a = lu_model(lu_sel_a, lu_op1_a, lu_op2_a);
  assign lu_res_b = ovr_en_b ? ovr_val_b : lu_model(lu_sel_b, lu_op1_b, lu_op2_b);
  assign lu_res_c = lu_model(lu_sel_c, lu_op1_c, lu_op2_c);

  // ---------------- DUTs ----------------
  l_instr_seq #(.EXEC_CYCLES(1), .LCD_EN(1'b1), .SEP_CHAR(8'h20)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_sel(req_sel), .req_op1(req_op1), .req_op2(req_op2),
    .lu_sel(lu_sel_a), .lu_op1(lu_op1_a), .lu_op2(lu_op2_a), .lu_res(lu_res_a),
    .res_valid(res_valid_a), .res_data(res_data_a), .res_err(res_err_a),
    .lcd_valid(lcd_valid_a), .lcd_ready(lcd_ready), .lcd_char(lcd_char_a),
    .busy(busy_a), .dbg_state(dbg_state_a)
  );

  l_instr_seq #(.EXEC_CYCLES(4), .LCD_EN(1'b0), .SEP_CHAR(8'h20)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_sel(req_sel), .req_op1(req_op1), .req_op2(req_op2),
    .lu_sel(lu_sel_b), .lu_op1(lu_op1_b), .lu_op2(lu_op2_b), .lu_res(lu_res_b),
    .res_valid(res_valid_b), .res_data(res_data_b), .res_err(res_err_b),
    .lcd_valid(lcd_valid_b), .lcd_ready(lcd_ready), .lcd_char(lcd_char_b),
    .busy(busy_b), .dbg_state(dbg_state_b)
  );

  l_instr_seq #(.EXEC_CYCLES(1), .LCD_EN(1'b0), .SEP_CHAR(8'h20)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid_c), .req_ready(req_ready_c),
    .req_sel(req_sel), .req_op1(req_op1), .req_op2(req_op2),
    .lu_sel(lu_sel_c), .lu_op1(lu_op1_c), .lu_op2(lu_op2_c), .lu_res(lu_res_c),
    .res_valid(res_valid_c), .res_data(res_data_c), .res_err(res_err_c),
    .lcd_valid(lcd_valid_c), .lcd_ready(lcd_ready), .lcd_char(lcd_char_c),
    .busy(busy_c), .dbg_state(dbg_state_c)
  );

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the back-to-back instance: every strobe pops one expectation.
  always @(negedge clk) begin
    if (res_valid_c) begin
      c_pulses++;
      if (exp_q.size() == 0) begin
        chk("c_unexpected_res_valid", 32'(res_data_c), 32'hFFFF_FFFF);
      end else begin
        chk("c_res_data_order", 32'(res_data_c), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [3:0] sel;
    logic [3:0] op1;
    logic [3:0] op2;
    int         stall;
    logic [7:0] data;
    logic       err;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vecs[7];

  // One full transaction on dut_a, starting from IDLE.
  // The first character is held off for v.stall cycles.
  task automatic run_a(input vec_t v);
    @(negedge clk);
    chk("a_req_ready_idle", 32'(req_ready_a), 32'd1);
    req_valid_a = 1'b1; req_sel = v.sel; req_op1 = v.op1; req_op2 = v.op2;
    @(negedge clk);                       // EXEC
    req_valid_a = 1'b0;
    chk("a_lu_sel", 32'(lu_sel_a), 32'(v.sel));
    chk("a_lu_op1", 32'(lu_op1_a), 32'(v.op1));
    chk("a_lu_op2", 32'(lu_op2_a), 32'(v.op2));
    chk("a_busy_exec", 32'(busy_a), 32'd1);
    chk("a_res_valid_exec", 32'(res_valid_a), 32'd0);
    lcd_ready = 1'b1;                     // must be ignored while lcd_valid=0
    @(negedge clk);                       // REPORT
    chk("a_res_valid", 32'(res_valid_a), 32'd1);
    chk("a_res_data", 32'(res_data_a), 32'(v.data));
    chk("a_res_err", 32'(res_err_a), 32'(v.err));
    chk("a_lcd_valid_report", 32'(lcd_valid_a), 32'd0);
    for (int k = 0; k <= v.stall; k++) begin
      @(negedge clk);                     // EMIT, char 0
      chk("a_lcd_valid_c0", 32'(lcd_valid_a), 32'd1);
      chk("a_lcd_char0", 32'(lcd_char_a), 32'(v.c0));
      chk("a_res_valid_once", 32'(res_valid_a), 32'd0);
      lcd_ready = (k == v.stall);
    end
    @(negedge clk);
    chk("a_lcd_valid_c1", 32'(lcd_valid_a), 32'd1);
    chk("a_lcd_char1", 32'(lcd_char_a), 32'(v.c1));
    @(negedge clk);
    chk("a_lcd_valid_c2", 32'(lcd_valid_a), 32'd1);
    chk("a_lcd_char2", 32'(lcd_char_a), 32'h20);
    chk("a_dbg_state_emit", 32'(dbg_state_a), 32'd3);
    @(negedge clk);                       // back in IDLE
    chk("a_lcd_valid_done", 32'(lcd_valid_a), 32'd0);
    chk("a_req_ready_done", 32'(req_ready_a), 32'd1);
    chk("a_busy_done", 32'(busy_a), 32'd0);
    chk("a_res_data_held", 32'(res_data_a), 32'(v.data));
    chk("a_lu_sel_retained", 32'(lu_sel_a), 32'(v.sel));
    lcd_ready = 1'b0;
  endtask

  initial begin
    //            sel   op1   op2  stall data   err   c0     c1
    vecs[0] = '{4'h0, 4'hC, 4'hA, 0, 8'h08, 1'b0, 8'h30, 8'h38}; // AND
    vecs[1] = '{4'h3, 4'h5, 4'h0, 4, 8'h0A, 1'b0, 8'h30, 8'h41}; // NOT, stalled
    vecs[2] = '{4'hB, 4'hF, 4'hF, 0, 8'h00, 1'b1, 8'h45, 8'h52}; // illegal
    vecs[3] = '{4'h1, 4'h9, 4'h6, 0, 8'h0F, 1'b0, 8'h30, 8'h46}; // OR
    vecs[4] = '{4'h4, 4'hF, 4'h3, 1, 8'h0C, 1'b0, 8'h30, 8'h43}; // NAND
    vecs[5] = '{4'h8, 4'h9, 4'h3, 0, 8'h48, 1'b0, 8'h34, 8'h38}; // SLL
    vecs[6] = '{4'h6, 4'hA, 4'h5, 0, 8'h00, 1'b0, 8'h30, 8'h30}; // XNOR

    // ---- reset state ----
    #2;
    chk("rst_req_ready", 32'(req_ready_a), 32'd0);
    chk("rst_lu", 32'({lu_sel_a, lu_op1_a, lu_op2_a}), 32'd0);
    chk("rst_res", 32'({res_valid_a, res_err_a, res_data_a}), 32'd0);
    chk("rst_lcd", 32'({lcd_valid_a, lcd_char_a}), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready_a), 32'd1);

    // ---- table-driven transactions on dut_a ----
    for (int i = 0; i < 7; i++) run_a(vecs[i]);

    // ---- EXEC_CYCLES=4, lu_res changed mid-EXEC (dut_b) ----
    @(negedge clk);
    ovr_en_b = 1'b1; ovr_val_b = 8'hAA;
    req_valid_b = 1'b1; req_sel = 4'h2; req_op1 = 4'h6; req_op2 = 4'h3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid_b = 1'b0;
      chk("b_lu_stable", 32'({lu_sel_b, lu_op1_b, lu_op2_b}), 32'h263);
      chk("b_res_valid_exec", 32'(res_valid_b), 32'd0);
      chk("b_req_ready_exec", 32'(req_ready_b), 32'd0);
      if (k == 2) ovr_val_b = 8'h77;
      if (k == 4) ovr_en_b = 1'b0;         // real unit value in the 4th cycle
    end
    @(negedge clk);                        // REPORT
    chk("b_res_valid", 32'(res_valid_b), 32'd1);
    chk("b_res_data", 32'(res_data_b), 32'h05);
    chk("b_req_ready_report", 32'(req_ready_b), 32'd0);
    @(negedge clk);
    chk("b_req_ready_back", 32'(req_ready_b), 32'd1);
    chk("b_res_valid_drop", 32'(res_valid_b), 32'd0);
    chk("b_lcd_valid_never", 32'(lcd_valid_b), 32'd0);

    // ---- asynchronous reset mid-EMIT (dut_a) ----
    @(negedge clk);
    req_valid_a = 1'b1; req_sel = 4'h0; req_op1 = 4'hC; req_op2 = 4'hA;
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);                        // REPORT
    lcd_ready = 1'b1;
    @(negedge clk);                        // char 0, handshake at next edge
    @(negedge clk);                        // char 1 showing
    chk("ar_pre_char1", 32'(lcd_char_a), 32'h38);
    #2 rst = 1'b1;
    #1;
    chk("ar_lcd_valid", 32'(lcd_valid_a), 32'd0);
    chk("ar_res_valid", 32'(res_valid_a), 32'd0);
    chk("ar_res_data", 32'(res_data_a), 32'd0);
    chk("ar_lu", 32'({lu_sel_a, lu_op1_a, lu_op2_a}), 32'd0);
    chk("ar_busy", 32'(busy_a), 32'd0);
    chk("ar_lcd_char", 32'(lcd_char_a), 32'd0);
    #1 rst = 1'b0;
    lcd_ready = 1'b0;
    @(negedge clk);
    chk("ar_after_idle", 32'({busy_a, lcd_valid_a, res_valid_a}), 32'd0);
    chk("ar_after_ready", 32'(req_ready_a), 32'd1);
    run_a(vecs[3]);

    // ---- back-to-back requests with req_valid held high (dut_c) ----
    @(negedge clk);
    req_valid_c = 1'b1; req_sel = 4'h0; req_op1 = 4'h3; req_op2 = 4'h5;
    for (int r = 0; r < 3; r++) begin
      chk("c_req_ready_accept", 32'(req_ready_c), 32'd1);
      exp_q.push_back((r == 0) ? 8'h01 : (r == 1) ? 8'h0C : 8'h0E);
      @(negedge clk);                      // EXEC
      chk("c_req_ready_exec", 32'(req_ready_c), 32'd0);
      chk("c_res_valid_exec", 32'(res_valid_c), 32'd0);
      if (r == 0) begin req_sel = 4'h1; req_op1 = 4'h8; req_op2 = 4'h4; end
      if (r == 1) begin req_sel = 4'h2; req_op1 = 4'hF; req_op2 = 4'h1; end
      @(negedge clk);                      // REPORT, strobe seen by scoreboard
      chk("c_res_valid", 32'(res_valid_c), 32'd1);
      @(negedge clk);                      // IDLE, next accept at coming edge
      chk("c_res_valid_drop", 32'(res_valid_c), 32'd0);
      if (r == 2) req_valid_c = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("c_pulse_count", 32'(c_pulses), 32'd3);
    chk("c_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/l_instr_seq.md
Name: l_instr_seq

Overview:
- Sequencer for the 4-bit logic unit (l_instr).
- Accepts one operation request at a time over a valid/ready handshake and drives the unit's sel/op1/op2 inputs.
- Holds those inputs stable for a programmable settle time, captures the 8-bit result and flags illegal opcodes.
- Optionally streams the result to the LCD character writer as ASCII hex plus a separator.

Parameters:
- EXEC_CYCLES, 1, cycles the unit's inputs are held before capture (legal range 1..15).
- LCD_EN, 1, when 1 the result is emitted to the LCD; when 0 the EMIT state is skipped.
- SEP_CHAR, 8'h20, separator character sent after the two hex digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_sel  in  4  opcode: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 NAND, 5 NOR, 6 XNOR, 7 SRL, 8 SLL.
- req_op1  in  4  operand 1.
- req_op2  in  4  operand 2.
- lu_sel  out  4  to logic unit sel.
- lu_op1  out  4  to logic unit op1.
- lu_op2  out  4  to logic unit op2.
- lu_res  in  8  from logic unit l_out.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  8  captured result, held until the next capture.
- res_err  out  1  opcode > 8, valid with res_valid and held with res_data.
- lcd_valid  out  1  character available.
- lcd_ready  in  1  LCD writer accepts the character.
- lcd_char  out  8  ASCII character.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; lu_sel/lu_op1/lu_op2 = 0; res_data = 0; res_err = 0; res_valid = 0; lcd_valid = 0; lcd_char = 0; settle counter = 0; char index = 0.
- req_ready = (state==IDLE) && !rst.
- States: IDLE, EXEC, REPORT, EMIT.
- IDLE: on req_valid && req_ready, latch req_* into lu_*, load counter = EXEC_CYCLES-1, go to EXEC. Otherwise stay; req_* are ignored while not ready.
- EXEC: lu_* stay constant. If counter != 0, decrement. If counter == 0:
  - capture res_data = (sel>8) ? 8'h00 : lu_res;
  - res_err = (sel>8);
  - go to REPORT.
- REPORT (exactly 1 cycle): res_valid = 1.
  - LCD_EN=1: next state EMIT, char index = 0.
  - LCD_EN=0: next state IDLE.
- EMIT: lcd_valid = 1 and lcd_char = char[index].
  - Normal result: char[0] = hex(res_data[7:4]), char[1] = hex(res_data[3:0]), char[2] = SEP_CHAR.
  - When res_err=1: char[0] = 8'h45 'E', char[1] = 8'h52 'R', char[2] = SEP_CHAR.
  - Hex digits are uppercase: 0-9 map to 8'h30-8'h39, A-F map to 8'h41-8'h46.
  - lcd_char stays stable while lcd_valid && !lcd_ready.
  - Each lcd_valid && lcd_ready edge advances the index. The handshake on index 2 returns to IDLE with lcd_valid = 0 in the following cycle.
  - No char-to-char gap is required: with lcd_ready held high, 3 consecutive valid cycles.
- Latency, EXEC_CYCLES=1:
  - accept at edge T; EXEC during cycle T..T+1; res_valid high during cycle T+1..T+2;
  - first character valid the cycle after REPORT;
  - with LCD_EN=0, req_ready returns in the cycle after REPORT.
- lu_* retain their last value in IDLE; they are not cleared after an operation.
- res_valid never asserts twice for one request. Back-to-back requests are accepted on the first IDLE cycle.
- Reset mid-operation (any state): all outputs return to reset values immediately and any partial LCD emission is abandoned. No res_valid is produced for the aborted request.
- An lcd_ready asserted while lcd_valid=0 is ignored.

Test Plan:
- Reset, then AND, op1=4'hC, op2=4'hA, LCD_EN=1, lcd_ready=1 -> lu_* = C/A/sel 0; res_valid 2 cycles after accept with res_data=8'h08, res_err=0; chars 8'h30, 8'h38, 8'h20 on 3 consecutive cycles; req_ready high the cycle after the last handshake.
- NOT op1=4'h5 with lcd_ready stalled low 4 cycles, then high -> res_data=8'h0A; lcd_char holds 8'h30 for 5 cycles, then 8'h41, then 8'h20.
- sel=4'hB, op1=4'hF, op2=4'hF -> res_data=8'h00, res_err=1; chars 8'h45, 8'h52, 8'h20.
- EXEC_CYCLES=4, LCD_EN=0, XOR 4'h6^4'h3, bench changes lu_res mid-EXEC -> lu_* stable 4 cycles; res_data captures the value present in the 4th EXEC cycle (8'h05 from the real unit); req_ready back 6 cycles after accept.
- rst pulsed asynchronously mid-EMIT after the first char -> lcd_valid, res_valid, res_data and lu_* drop to 0 without a clock edge; busy=0; the next request completes normally.
- req_valid held high for 3 back-to-back requests with LCD_EN=0 -> exactly 3 res_valid pulses in request order, one per request, each 2 cycles after its accept.
